adt_rdparse: RTL and testbench

ADT_RDPARSE -- requirements
Module: adt_rdparse

---
 rtl/adt_rdparse.sv | 184 ++++++++++++++++++
 tb/tb_adt_rdparse.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adt_rdparse.sv
// ADT7310 read-frame parser: validates completed SPI read frames and
// updates the status, configuration, temperature and ID shadow registers.
// A three-state pipeline (IDLE -> CHECK -> UPDATE) gives a fixed two-cycle latency.
module adt_rdparse #(
    parameter logic [7:0]  CON_EXP   = 8'h0C,
    parameter logic [4:0]  MAN_ID    = 5'b11000,
    parameter logic [23:0] STALE_CYC = 24'd12_500_000
) (
    input  logic        clk_sys,
    input  logic        rst_sys,
    input  logic        rd_vld,
    input  logic [7:0]  rd_cmd,
    input  logic [5:0]  rd_len,
    input  logic [15:0] rd_data,
    output logic [7:0]  stu_reg,
    output logic [7:0]  con_reg,
    output logic [15:0] temp_raw,
    output logic [12:0] temp_q4,
    output logic        temp_vld,
    output logic        alm_crit,
    output logic        alm_high,
    output logic        alm_low,
    output logic        con_bad,
    output logic        id_bad,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic        stale
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StCheck  = 2'd1;
    localparam logic [1:0] StUpdate = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [5:0]  len_q, len_d;
    logic [15:0] data_q, data_d;
    logic        acc_q, acc_d;
    logic [7:0]  stu_q, stu_d;
    logic [7:0]  con_q, con_d;
    logic [15:0] temp_q, temp_d;
    logic        temp_vld_q, temp_vld_d;
    logic        con_bad_q, con_bad_d;
    logic        id_bad_q, id_bad_d;
    logic        ferr_q, ferr_d;
    logic [7:0]  err_q, err_d;
    logic [23:0] stale_cnt_q, stale_cnt_d;

    logic        cmd_ok;
    logic        len_ok;
    logic [1:0]  n_err;
    logic [8:0]  err_sum;

    // Frame legality from the latched command and length.
    always_comb begin
        cmd_ok = cmd_q[6] & ~cmd_q[7] & (cmd_q[2:0] == 3'b000);
        unique case (cmd_q[5:3])
            3'd0, 3'd1, 3'd3: len_ok = (len_q == 6'd16);
            3'd2:             len_ok = (len_q == 6'd24);
            default:          len_ok = 1'b1;  // unused registers: accepted, no update
        endcase
    end

    // Next-state: FSM, holding registers, shadow registers, error and stale counters.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        data_d      = data_q;
        acc_d       = acc_q;
        stu_d       = stu_q;
        con_d       = con_q;
        temp_d      = temp_q;
        con_bad_d   = con_bad_q;
        id_bad_d    = id_bad_q;
        temp_vld_d  = 1'b0;
        ferr_d      = 1'b0;
        n_err       = 2'd0;

        case (state_q)
            StIdle: begin
                if (rd_vld) begin
                    cmd_d   = rd_cmd;
                    len_d   = rd_len;
                    data_d  = rd_data;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                acc_d   = cmd_ok & len_ok;
                state_d = StUpdate;
            end
            StUpdate: begin
                state_d = StIdle;
                if (acc_q) begin
                    case (cmd_q[5:3])
                        3'd0: stu_d = data_q[7:0];
                        3'd1: begin
                            con_d     = data_q[7:0];
                            con_bad_d = (data_q[7:0] != CON_EXP);
                        end
                        3'd2: begin
                            temp_d     = data_q;
                            temp_vld_d = 1'b1;
                        end
                        3'd3: id_bad_d = (data_q[7:3] != MAN_ID);
                        default: ;
                    endcase
                end else begin
                    ferr_d = 1'b1;
                    n_err  = n_err + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A frame arriving while the previous one is still in flight is dropped.
        if (rd_vld && (state_q != StIdle)) begin
            ferr_d = 1'b1;
            n_err  = n_err + 2'd1;
        end

        err_sum = {1'b0, err_q} + {7'b0, n_err};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

        if (temp_vld_d) begin
            stale_cnt_d = '0;
        end else if (stale_cnt_q == STALE_CYC) begin
            stale_cnt_d = stale_cnt_q;
        end else begin
            stale_cnt_d = stale_cnt_q + 24'd1;
        end
    end

    // State registers with synchronous reset; reset also cancels any pending pulse.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            acc_q       <= 1'b0;
            stu_q       <= 8'h80;
            con_q       <= '0;
            temp_q      <= '0;
            temp_vld_q  <= 1'b0;
            con_bad_q   <= 1'b0;
            id_bad_q    <= 1'b0;
            ferr_q      <= 1'b0;
            err_q       <= '0;
            stale_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            data_q      <= data_d;
            acc_q       <= acc_d;
            stu_q       <= stu_d;
            con_q       <= con_d;
            temp_q      <= temp_d;
            temp_vld_q  <= temp_vld_d;
            con_bad_q   <= con_bad_d;
            id_bad_q    <= id_bad_d;
            ferr_q      <= ferr_d;
            err_q       <= err_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    assign stu_reg   = stu_q;
    assign con_reg   = con_q;
    assign temp_raw  = temp_q;
    assign temp_q4   = temp_q[15:3];
    assign temp_vld  = temp_vld_q;
    assign alm_crit  = stu_q[6];
    assign alm_high  = stu_q[5];
    assign alm_low   = stu_q[4];
    assign con_bad   = con_bad_q;
    assign id_bad    = id_bad_q;
    assign frame_err = ferr_q;
    assign err_cnt   = err_q;
    assign stale     = (stale_cnt_q == STALE_CYC);

endmodule

// File: tb/tb_adt_rdparse.sv
// Bench for adt_rdparse: directed scenarios plus randomized frames checked
// against a frame-level reference model of the register semantics.
module tb_adt_rdparse;

    logic        clk_sys = 1'b0;
    logic        rst_sys = 1'b1;
    logic        rd_vld = 1'b0;
    logic [7:0]  rd_cmd = '0;
    logic [5:0]  rd_len = '0;
    logic [15:0] rd_data = '0;
    logic [7:0]  stu_reg, con_reg, err_cnt;
    logic [15:0] temp_raw;
    logic [12:0] temp_q4;
    logic        temp_vld, alm_crit, alm_high, alm_low, con_bad, id_bad, frame_err, stale;

    always #5 clk_sys = ~clk_sys;

    adt_rdparse #(.STALE_CYC(24'd16)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .rd_vld(rd_vld), .rd_cmd(rd_cmd),
        .rd_len(rd_len), .rd_data(rd_data), .stu_reg(stu_reg), .con_reg(con_reg),
        .temp_raw(temp_raw), .temp_q4(temp_q4), .temp_vld(temp_vld),
        .alm_crit(alm_crit), .alm_high(alm_high), .alm_low(alm_low),
        .con_bad(con_bad), .id_bad(id_bad), .frame_err(frame_err),
        .err_cnt(err_cnt), .stale(stale)
    );

    int n_ok = 0;
    int n_chk = 0;

    // Reference model state
    logic [7:0]  m_stu, m_con;
    logic [15:0] m_temp;
    logic        m_con_bad, m_id_bad, e_tvld, e_ferr;
    int          m_err;

    task automatic model_reset();
        m_stu = 8'h80; m_con = 8'h00; m_temp = 16'h0000;
        m_con_bad = 1'b0; m_id_bad = 1'b0; m_err = 0; e_tvld = 1'b0; e_ferr = 1'b0;
    endtask

    function automatic int clamp_err(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_apply(input logic [7:0] c, input logic [5:0] l, input logic [15:0] d);
        int a;
        bit ok;
        a  = int'(c[5:3]);
        ok = (c[7] == 1'b0) && (c[6] == 1'b1) && (c[2:0] == 3'b000);
        if (a == 2) ok = ok && (l == 6'd24);
        else if (a < 4) ok = ok && (l == 6'd16);
        e_tvld = 1'b0;
        e_ferr = 1'b0;
        if (!ok) begin
            e_ferr = 1'b1;
            m_err  = clamp_err(m_err + 1);
        end else if (a == 0) begin
            m_stu = d[7:0];
        end else if (a == 1) begin
            m_con = d[7:0];
            m_con_bad = (d[7:0] != 8'h0C);
        end else if (a == 2) begin
            m_temp = d;
            e_tvld = 1'b1;
        end else if (a == 3) begin
            m_id_bad = (d[7:3] != 5'b11000);
        end
    endtask

    // Drive one frame, then sit at two edges later (+1) with the model updated.
    task automatic send(input logic [7:0] c, input logic [5:0] l, input logic [15:0] d);
        @(negedge clk_sys);
        rd_cmd = c; rd_len = l; rd_data = d; rd_vld = 1'b1;
        @(negedge clk_sys);
        rd_vld = 1'b0;
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        model_apply(c, l, d);
    endtask

    task automatic test_reset();
        rst_sys = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        n_chk++; if (stu_reg !== 8'h80) $display("FAIL rst_stu got=%h exp=80", stu_reg); else n_ok++;
        n_chk++; if (con_reg !== 8'h00) $display("FAIL rst_con got=%h exp=00", con_reg); else n_ok++;
        n_chk++; if (temp_raw !== 16'h0) $display("FAIL rst_temp got=%h exp=0", temp_raw); else n_ok++;
        n_chk++; if ({temp_vld, frame_err, stale} !== 3'b000)
            $display("FAIL rst_pulses got=%b exp=000", {temp_vld, frame_err, stale}); else n_ok++;
        n_chk++; if ({alm_crit, alm_high, alm_low, con_bad, id_bad} !== 5'b0)
            $display("FAIL rst_flags got=%b exp=00000", {alm_crit, alm_high, alm_low, con_bad, id_bad});
        else n_ok++;
        n_chk++; if (err_cnt !== 8'h00) $display("FAIL rst_err got=%h exp=00", err_cnt); else n_ok++;
    endtask

    task automatic test_stale();
        @(negedge clk_sys);
        rst_sys = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk_sys);
            #1;
            if (k == 15) begin
                n_chk++; if (stale !== 1'b0) $display("FAIL stale_15 got=%b exp=0", stale); else n_ok++;
            end
            if (k == 16) begin
                n_chk++; if (stale !== 1'b1) $display("FAIL stale_16 got=%b exp=1", stale); else n_ok++;
            end
        end
        @(negedge clk_sys);
        rd_cmd = 8'h50; rd_len = 6'd24; rd_data = 16'h0C80; rd_vld = 1'b1;
        @(negedge clk_sys);
        rd_vld = 1'b0;
        @(posedge clk_sys);
        #1;
        n_chk++; if ({temp_vld, stale} !== 2'b01)
            $display("FAIL temp_n1 got=%b exp=01", {temp_vld, stale}); else n_ok++;
        @(posedge clk_sys);
        #1;
        model_apply(8'h50, 6'd24, 16'h0C80);
        n_chk++; if (temp_raw !== 16'h0C80) $display("FAIL temp_raw got=%h exp=0c80", temp_raw); else n_ok++;
        n_chk++; if (temp_q4 !== 13'h0190) $display("FAIL temp_q4 got=%h exp=0190", temp_q4); else n_ok++;
        n_chk++; if ({temp_vld, stale} !== 2'b10)
            $display("FAIL temp_n2 got=%b exp=10", {temp_vld, stale}); else n_ok++;
        @(posedge clk_sys);
        #1;
        n_chk++; if (temp_vld !== 1'b0) $display("FAIL temp_vld_width got=%b exp=0", temp_vld); else n_ok++;
    endtask

    task automatic test_directed();
        send(8'h40, 6'd16, 16'h0070);
        n_chk++; if (stu_reg !== 8'h70) $display("FAIL stu got=%h exp=70", stu_reg); else n_ok++;
        n_chk++; if ({alm_crit, alm_high, alm_low} !== 3'b111)
            $display("FAIL alarms got=%b exp=111", {alm_crit, alm_high, alm_low}); else n_ok++;
        send(8'h48, 6'd16, 16'h0024);
        n_chk++; if ({con_reg, con_bad} !== {8'h24, 1'b1})
            $display("FAIL con got=%h/%b exp=24/1", con_reg, con_bad); else n_ok++;
        send(8'h48, 6'd16, 16'h000C);
        n_chk++; if (con_bad !== 1'b0) $display("FAIL con_ok got=%b exp=0", con_bad); else n_ok++;
        send(8'h58, 6'd16, 16'h0000);
        n_chk++; if (id_bad !== 1'b1) $display("FAIL id_bad got=%b exp=1", id_bad); else n_ok++;
        send(8'h58, 6'd16, 16'h00C5);
        n_chk++; if (id_bad !== 1'b0) $display("FAIL id_ok got=%b exp=0", id_bad); else n_ok++;
        send(8'h50, 6'd16, 16'hFFFF);
        n_chk++; if ({frame_err, err_cnt} !== {1'b1, 8'd1})
            $display("FAIL len_rej got=%b/%0d exp=1/1", frame_err, err_cnt); else n_ok++;
        n_chk++; if (temp_raw !== 16'h0C80) $display("FAIL rej_temp got=%h exp=0c80", temp_raw); else n_ok++;
        send(8'h10, 6'd16, 16'h0000);
        n_chk++; if (err_cnt !== 8'd2) $display("FAIL rd_bit_rej got=%0d exp=2", err_cnt); else n_ok++;
        send(8'h60, 6'd5, 16'h1234);
        n_chk++; if ({frame_err, err_cnt, temp_raw} !== {1'b0, 8'd2, 16'h0C80})
            $display("FAIL addr4 got=%b/%0d/%h exp=0/2/0c80", frame_err, err_cnt, temp_raw);
        else n_ok++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] d1;
        d1 = 16'($urandom);
        @(negedge clk_sys);
        rd_cmd = 8'h50; rd_len = 6'd24; rd_data = d1; rd_vld = 1'b1;
        @(negedge clk_sys);
        rd_cmd = 8'h40; rd_len = 6'd16; rd_data = 16'h00FF;
        @(posedge clk_sys);
        #1;
        m_err = clamp_err(m_err + 1);
        n_chk++; if ({frame_err, err_cnt} !== {1'b1, 8'(m_err)})
            $display("FAIL b2b_drop got=%b/%0d exp=1/%0d", frame_err, err_cnt, m_err); else n_ok++;
        @(negedge clk_sys);
        rd_vld = 1'b0;
        @(posedge clk_sys);
        #1;
        model_apply(8'h50, 6'd24, d1);
        n_chk++; if ({temp_vld, frame_err, temp_raw} !== {2'b10, d1})
            $display("FAIL b2b_first got=%b%b/%h exp=10/%h", temp_vld, frame_err, temp_raw, d1);
        else n_ok++;
        n_chk++; if (stu_reg !== m_stu) $display("FAIL b2b_stu got=%h exp=%h", stu_reg, m_stu); else n_ok++;
    endtask

    task automatic test_simultaneous();
        @(negedge clk_sys);
        rd_cmd = 8'h50; rd_len = 6'd16; rd_data = 16'h0000; rd_vld = 1'b1;
        @(negedge clk_sys);
        rd_vld = 1'b0;
        @(negedge clk_sys);
        rd_cmd = 8'h50; rd_len = 6'd24; rd_data = 16'h7FF8; rd_vld = 1'b1;
        @(posedge clk_sys);
        #1;
        m_err = clamp_err(m_err + 2);
        n_chk++; if ({frame_err, err_cnt} !== {1'b1, 8'(m_err)})
            $display("FAIL simul got=%b/%0d exp=1/%0d", frame_err, err_cnt, m_err); else n_ok++;
        @(negedge clk_sys);
        rd_vld = 1'b0;
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        n_chk++; if ({temp_vld, temp_raw} !== {1'b0, m_temp})
            $display("FAIL simul_drop got=%b/%h exp=0/%h", temp_vld, temp_raw, m_temp); else n_ok++;
    endtask

    task automatic test_random();
        logic [7:0]  c;
        logic [5:0]  l;
        logic [15:0] d;
        logic [12:0] e_q4;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 8) c = {2'b01, 3'($urandom_range(0, 7)), 3'b000};
            else c = 8'($urandom);
            case ($urandom_range(0, 2))
                0: l = 6'd16;
                1: l = 6'd24;
                default: l = 6'($urandom);
            endcase
            d = 16'($urandom);
            send(c, l, d);
            e_q4 = 13'($signed(m_temp) >>> 3);
            n_chk++; if (stu_reg !== m_stu) $display("FAIL rnd_stu got=%h exp=%h", stu_reg, m_stu); else n_ok++;
            n_chk++; if (con_reg !== m_con) $display("FAIL rnd_con got=%h exp=%h", con_reg, m_con); else n_ok++;
            n_chk++; if (temp_raw !== m_temp) $display("FAIL rnd_temp got=%h exp=%h", temp_raw, m_temp); else n_ok++;
            n_chk++; if (temp_q4 !== e_q4) $display("FAIL rnd_q4 got=%h exp=%h", temp_q4, e_q4); else n_ok++;
            n_chk++; if ({alm_crit, alm_high, alm_low} !== m_stu[6:4])
                $display("FAIL rnd_alm got=%b exp=%b", {alm_crit, alm_high, alm_low}, m_stu[6:4]); else n_ok++;
            n_chk++; if ({con_bad, id_bad} !== {m_con_bad, m_id_bad})
                $display("FAIL rnd_bad got=%b exp=%b", {con_bad, id_bad}, {m_con_bad, m_id_bad}); else n_ok++;
            n_chk++; if ({temp_vld, frame_err} !== {e_tvld, e_ferr})
                $display("FAIL rnd_pulse got=%b exp=%b", {temp_vld, frame_err}, {e_tvld, e_ferr}); else n_ok++;
            n_chk++; if (err_cnt !== 8'(m_err)) $display("FAIL rnd_err got=%0d exp=%0d", err_cnt, m_err); else n_ok++;
            if (e_tvld) begin
                n_chk++; if (stale !== 1'b0) $display("FAIL rnd_stale got=%b exp=0", stale); else n_ok++;
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) send(8'h10, 6'd16, 16'h0000);
        n_chk++; if ({frame_err, err_cnt} !== {1'b1, 8'hFF})
            $display("FAIL sat got=%b/%h exp=1/ff", frame_err, err_cnt); else n_ok++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk_sys);
        rd_cmd = 8'h50; rd_len = 6'd24; rd_data = 16'h1234; rd_vld = 1'b1;
        @(negedge clk_sys);
        rd_vld = 1'b0;
        rst_sys = 1'b1;
        model_reset();
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        n_chk++; if ({temp_vld, frame_err, temp_raw, err_cnt, stu_reg} !== {2'b00, 16'h0, 8'h00, 8'h80})
            $display("FAIL rst_mid got=%b%b/%h/%h/%h exp=00/0000/00/80",
                     temp_vld, frame_err, temp_raw, err_cnt, stu_reg);
        else n_ok++;
        @(negedge clk_sys);
        rst_sys = 1'b0;
        rd_cmd = 8'h50; rd_len = 6'd24; rd_data = 16'hFE70; rd_vld = 1'b1;
        @(negedge clk_sys);
        rd_vld = 1'b0;
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        model_apply(8'h50, 6'd24, 16'hFE70);
        n_chk++; if ({temp_vld, temp_raw} !== {1'b1, m_temp})
            $display("FAIL first_edge got=%b/%h exp=1/%h", temp_vld, temp_raw, m_temp); else n_ok++;
        n_chk++; if (temp_q4 !== 13'h1FCE) $display("FAIL neg_q4 got=%h exp=1fce", temp_q4); else n_ok++;
    endtask

    initial begin
        test_reset();
        test_stale();
        test_directed();
        test_back_to_back();
        test_simultaneous();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
